// File: rtl/dcache_pkg.sv
// Shared types, address-field widths and field helpers for the MEM-stage data cache.
package dcache_pkg;

  localparam int LINE_ADDR_LEN = 3;
  localparam int SET_ADDR_LEN  = 2;
  localparam int TAG_ADDR_LEN  = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int LINE_SIZE     = 1 << LINE_ADDR_LEN;
  localparam int SET_SIZE      = 1 << SET_ADDR_LEN;

  typedef logic [31:0]               word_t;
  typedef logic [TAG_ADDR_LEN-1:0]   tag_t;
  typedef logic [SET_ADDR_LEN-1:0]   set_t;
  typedef logic [LINE_ADDR_LEN-1:0]  wsel_t;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_e;

  function automatic tag_t addr_tag(input word_t a);
    return a[31:32-TAG_ADDR_LEN];
  endfunction

  function automatic set_t addr_set(input word_t a);
    return a[2+LINE_ADDR_LEN +: SET_ADDR_LEN];
  endfunction

  function automatic wsel_t addr_word(input word_t a);
    return a[2 +: LINE_ADDR_LEN];
  endfunction

  function automatic word_t beat_addr(input tag_t t, input set_t s, input wsel_t w);
    return {t, s, w, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Core-side request bus and memory-side burst bus of the data cache.
interface dcache_ctrl_if;
  import dcache_pkg::*;

  logic       rd_req;
  logic       wr_req;
  word_t      addr;
  word_t      wr_data;
  logic [3:0] byte_en;
  word_t      rd_data;
  logic       miss;
  word_t      miss_count;
  logic       mem_req;
  logic       mem_we;
  word_t      mem_addr;
  word_t      mem_wdata;
  word_t      mem_rdata;
  logic       mem_ack;

  modport slave (
    input  rd_req, wr_req, addr, wr_data, byte_en, mem_rdata, mem_ack,
    output rd_data, miss, miss_count, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rd_req, wr_req, addr, wr_data, byte_en, mem_rdata, mem_ack,
    input  rd_data, miss, miss_count, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dcache_line_ram.sv
// Cache data array: byte-enabled synchronous write, combinational read of one line word.
module dcache_line_ram
  import dcache_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  set_t       set_sel,
  input  wsel_t      word_sel,
  input  logic [3:0] be,
  input  word_t      wdata,
  output word_t      rdata
);

  word_t mem [SET_SIZE*LINE_SIZE];
  logic [SET_ADDR_LEN+LINE_ADDR_LEN-1:0] idx;

  assign idx = {set_sel, word_sel};

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller with word-serial
// write-back and fill bursts; the core stalls on `miss` until the request hits.
module dcache_ctrl
  import dcache_pkg::*;
(
  input logic          clk,
  input logic          rst,
  dcache_ctrl_if.slave bus
);

  state_e              state_q, state_d;
  wsel_t               word_cnt_q, word_cnt_d;
  logic [SET_SIZE-1:0] valid_q, valid_d;
  logic [SET_SIZE-1:0] dirty_q, dirty_d;
  tag_t                tag_q [SET_SIZE];
  tag_t                tag_d [SET_SIZE];
  tag_t                victim_q, victim_d;
  word_t               miss_count_q, miss_count_d;
  word_t               rd_data_q, rd_data_d;

  logic       req, hit;
  tag_t       req_tag;
  set_t       req_set;
  wsel_t      req_word;
  logic       ram_we;
  wsel_t      ram_word;
  logic [3:0] ram_be;
  word_t      ram_wdata, ram_rdata;
  logic       unused_addr_lsbs;

  assign req_tag          = addr_tag(bus.addr);
  assign req_set          = addr_set(bus.addr);
  assign req_word         = addr_word(bus.addr);
  assign unused_addr_lsbs = ^bus.addr[1:0];
  assign req              = bus.rd_req | bus.wr_req;
  assign hit              = valid_q[req_set] && (tag_q[req_set] == req_tag);
  assign ram_word         = (state_q == IDLE) ? req_word : word_cnt_q;

  dcache_line_ram u_ram (
    .clk      (clk),
    .we       (ram_we),
    .set_sel  (req_set),
    .word_sel (ram_word),
    .be       (ram_be),
    .wdata    (ram_wdata),
    .rdata    (ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    victim_d     = victim_q;
    miss_count_d = miss_count_q;
    rd_data_d    = rd_data_q;
    ram_we       = 1'b0;
    ram_be       = 4'h0;
    ram_wdata    = bus.wr_data;

    case (state_q)
      IDLE: begin
        if (req && hit) begin
          // A simultaneous read and write is serviced as a store only.
          if (bus.wr_req) begin
            ram_we           = 1'b1;
            ram_be           = bus.byte_en;
            dirty_d[req_set] = 1'b1;
          end else begin
            rd_data_d = ram_rdata;
          end
        end else if (req) begin
          miss_count_d = miss_count_q + 32'd1;
          word_cnt_d   = '0;
          victim_d     = tag_q[req_set];
          state_d      = (valid_q[req_set] && dirty_q[req_set]) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        if (bus.mem_ack) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (&word_cnt_q) begin
            dirty_d[req_set] = 1'b0;
            state_d          = FILL;
          end
        end
      end
      FILL: begin
        if (bus.mem_ack) begin
          ram_we     = 1'b1;
          ram_be     = 4'hF;
          ram_wdata  = bus.mem_rdata;
          word_cnt_d = word_cnt_q + 1'b1;
          if (&word_cnt_q) begin
            tag_d[req_set]   = req_tag;
            valid_d[req_set] = 1'b1;
            dirty_d[req_set] = 1'b0;
            state_d          = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      victim_q     <= '0;
      miss_count_q <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      victim_q     <= victim_d;
      miss_count_q <= miss_count_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Tags are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.miss_count = miss_count_q;
  assign bus.miss       = (state_q != IDLE) | (req & ~hit);
  assign bus.mem_req    = (state_q != IDLE);
  assign bus.mem_we     = (state_q == WRITEBACK);
  assign bus.mem_wdata  = (state_q == WRITEBACK) ? ram_rdata : '0;
  assign bus.mem_addr   = (state_q == WRITEBACK) ? beat_addr(victim_q, req_set, word_cnt_q) :
                          (state_q == FILL)      ? beat_addr(req_tag,  req_set, word_cnt_q) :
                                                   '0;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: table-driven hit vectors plus hand-written miss,
// write-back, stall and reset-abort sequences against a small main-memory model.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic ack_en;
  logic stray_ack;

  typedef struct {
    word_t addr;
    logic  we;
    word_t wdata;
  } beat_t;

  typedef struct {
    string      name;
    logic       rd;
    logic       wr;
    word_t      addr;
    word_t      wdata;
    logic [3:0] be;
    logic       exp_miss;
    word_t      exp_rd;
    word_t      exp_cnt;
  } vec_t;

  beat_t beats[$];
  word_t mem_model [256];
  vec_t  vecs [7];

  dcache_ctrl_if bus();

  dcache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Main-memory model: answers one beat per cycle while ack_en is set.
  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 32'h1000 + i;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_req && ack_en) begin
        bus.mem_ack = 1'b1;
        if (bus.mem_we) begin
          mem_model[bus.mem_addr[9:2]] = bus.mem_wdata;
          bus.mem_rdata = '0;
        end else begin
          bus.mem_rdata = mem_model[bus.mem_addr[9:2]];
        end
        beats.push_back('{bus.mem_addr, bus.mem_we, bus.mem_wdata});
      end else if (stray_ack) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0BAD0;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input word_t actual, input word_t expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic driveReq(input logic rd, input logic wr, input word_t a,
                          input word_t wd, input logic [3:0] be);
    @(negedge clk);
    bus.rd_req  = rd;
    bus.wr_req  = wr;
    bus.addr    = a;
    bus.wr_data = wd;
    bus.byte_en = be;
  endtask

  task automatic idleBus();
    @(negedge clk);
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    driveReq(v.rd, v.wr, v.addr, v.wdata, v.be);
    #1;
    checkOutput({v.name, " miss"}, 32'(bus.miss), 32'(v.exp_miss));
    @(posedge clk);
    #1;
    checkOutput({v.name, " rd_data"}, bus.rd_data, v.exp_rd);
    checkOutput({v.name, " miss_count"}, bus.miss_count, v.exp_cnt);
  endtask

  // Called mid-cycle; returns just after a falling edge with miss low, or flags a timeout.
  task automatic waitNoMiss(input string name, input int bound);
    int n = 0;
    #1;
    while (bus.miss !== 1'b0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({name, " miss released"}, 32'(bus.miss), 32'd0);
  endtask

  task automatic waitBeats(input string name, input int target, input int bound);
    int n = 0;
    while (beats.size() < target && n < bound) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput({name, " beats reached"}, 32'(beats.size()), 32'(target));
  endtask

  task automatic checkBeats(input string name, input int base, input word_t first_addr,
                            input logic exp_we);
    for (int i = 0; i < LINE_SIZE; i++) begin
      if (base + i < beats.size()) begin
        checkOutput($sformatf("%s beat%0d addr", name, i), beats[base+i].addr,
                    first_addr + 32'(4*i));
        checkOutput($sformatf("%s beat%0d we", name, i), 32'(beats[base+i].we), 32'(exp_we));
      end else begin
        checkOutput($sformatf("%s beat%0d present", name, i), 32'(beats.size()), 32'(base + i + 1));
      end
    end
  endtask

  initial begin
    int base;

    vecs[0] = '{"store 0x10 b0", 1'b0, 1'b1, 32'h10, 32'h000000AB, 4'b0001, 1'b0, 32'h00001004, 32'd1};
    vecs[1] = '{"read 0x10",     1'b1, 1'b0, 32'h10, 32'h0,        4'b0000, 1'b0, 32'h000010AB, 32'd1};
    vecs[2] = '{"store 0x14 hi", 1'b0, 1'b1, 32'h14, 32'hDEAD0000, 4'b1100, 1'b0, 32'h000010AB, 32'd1};
    vecs[3] = '{"read 0x14",     1'b1, 1'b0, 32'h14, 32'h0,        4'b0000, 1'b0, 32'hDEAD1005, 32'd1};
    vecs[4] = '{"rd+wr 0x18",    1'b1, 1'b1, 32'h18, 32'h00005500, 4'b0010, 1'b0, 32'hDEAD1005, 32'd1};
    vecs[5] = '{"read 0x18",     1'b1, 1'b0, 32'h18, 32'h0,        4'b0000, 1'b0, 32'h00005506, 32'd1};
    vecs[6] = '{"read 0x1C",     1'b1, 1'b0, 32'h1C, 32'h0,        4'b0000, 1'b0, 32'h00001007, 32'd1};

    ack_en      = 1'b1;
    stray_ack   = 1'b0;
    bus.rd_req  = 1'b0;
    bus.wr_req  = 1'b0;
    bus.addr    = '0;
    bus.wr_data = '0;
    bus.byte_en = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #10;
    checkOutput("reset miss", 32'(bus.miss), 32'd0);
    checkOutput("reset mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("reset mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("reset mem_addr", bus.mem_addr, 32'd0);
    checkOutput("reset mem_wdata", bus.mem_wdata, 32'd0);
    checkOutput("reset miss_count", bus.miss_count, 32'd0);
    checkOutput("reset rd_data", bus.rd_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] cold read miss");
    base = beats.size();
    driveReq(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    #1;
    checkOutput("cold miss request cycle", 32'(bus.miss), 32'd1);
    waitNoMiss("cold", 60);
    @(posedge clk);
    #1;
    checkOutput("cold rd_data", bus.rd_data, 32'h00001004);
    checkOutput("cold miss_count", bus.miss_count, 32'd1);
    checkOutput("cold beat total", 32'(beats.size() - base), 32'd8);
    checkBeats("cold fill", base, 32'h0, 1'b0);
    idleBus();

    $display("[TB] hit vectors");
    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);
    idleBus();

    $display("[TB] dirty eviction");
    base = beats.size();
    driveReq(1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
    #1;
    checkOutput("evict miss request cycle", 32'(bus.miss), 32'd1);
    waitNoMiss("evict", 80);
    @(posedge clk);
    #1;
    checkOutput("evict rd_data", bus.rd_data, 32'h00001020);
    checkOutput("evict miss_count", bus.miss_count, 32'd2);
    checkOutput("evict beat total", 32'(beats.size() - base), 32'd16);
    checkBeats("evict wb", base, 32'h0, 1'b1);
    checkBeats("evict fill", base + 8, 32'h80, 1'b0);
    if (beats.size() >= base + 8) begin
      checkOutput("wb beat0 data", beats[base+0].wdata, 32'h00001000);
      checkOutput("wb beat4 data", beats[base+4].wdata, 32'h000010AB);
      checkOutput("wb beat5 data", beats[base+5].wdata, 32'hDEAD1005);
      checkOutput("wb beat6 data", beats[base+6].wdata, 32'h00005506);
    end
    idleBus();

    $display("[TB] clean miss with stalled memory");
    base = beats.size();
    driveReq(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    #1;
    checkOutput("clean miss request cycle", 32'(bus.miss), 32'd1);
    waitBeats("clean pre-stall", base + 3, 40);
    ack_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      checkOutput($sformatf("stall%0d mem_addr", i), bus.mem_addr, 32'h0000000C);
      checkOutput($sformatf("stall%0d miss", i), 32'(bus.miss), 32'd1);
    end
    ack_en = 1'b1;
    waitNoMiss("clean", 60);
    @(posedge clk);
    #1;
    checkOutput("clean rd_data", bus.rd_data, 32'h000010AB);
    checkOutput("clean miss_count", bus.miss_count, 32'd3);
    checkOutput("clean beat total", 32'(beats.size() - base), 32'd8);
    checkBeats("clean fill", base, 32'h0, 1'b0);
    idleBus();

    $display("[TB] reset during fill");
    base = beats.size();
    driveReq(1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
    waitBeats("abort pre-reset", base + 3, 40);
    rst = 1'b1;
    bus.rd_req = 1'b0;
    #1;
    checkOutput("abort mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("abort miss", 32'(bus.miss), 32'd0);
    checkOutput("abort miss_count", bus.miss_count, 32'd0);
    checkOutput("abort mem_addr", bus.mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stray_ack = 1'b1;
    @(posedge clk);
    #2;
    stray_ack = 1'b0;
    checkOutput("stray ack mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("stray ack miss", 32'(bus.miss), 32'd0);
    checkOutput("stray ack miss_count", bus.miss_count, 32'd0);
    driveReq(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    #1;
    checkOutput("post-reset miss request cycle", 32'(bus.miss), 32'd1);
    waitNoMiss("post-reset", 60);
    @(posedge clk);
    #1;
    checkOutput("post-reset rd_data", bus.rd_data, 32'h000010AB);
    checkOutput("post-reset miss_count", bus.miss_count, 32'd1);
    idleBus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache for the MEM stage of the RV32I pipeline. It replaces the flat data RAM behind the MEM/WB data path.
- Core side: MEM-stage loads and stores, with `miss` driven to the hazard unit so the core stalls.
- Memory side: a word-serial burst interface to main memory.
- The WB-stage register captures `rd_data` exactly as it captures the flat-RAM read data today.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line (8 words = 32 B).
- SET_ADDR_LEN, 2, log2 of sets (4 sets, 128 B total).
- TAG_ADDR_LEN, derived as 30 - LINE_ADDR_LEN - SET_ADDR_LEN (25 bits at defaults). Not overridable.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- rd_req  in  1  load request this cycle.
- wr_req  in  1  store request this cycle.
- addr  in  32  byte address; bits [1:0] ignored.
- wr_data  in  32  store data, lane-aligned.
- byte_en  in  4  store byte-lane enables.
- rd_data  out  32  load data, registered.
- miss  out  1  stall request to the hazard unit.
- miss_count  out  32  number of misses since reset.
- mem_req  out  1  burst active.
- mem_we  out  1  1 = write-back burst, 0 = fill burst.
- mem_addr  out  32  current beat word address {tag, set, word_cnt, 2'b00}.
- mem_wdata  out  32  write-back beat data.
- mem_rdata  in  32  fill beat data, valid when mem_ack is high.
- mem_ack  in  1  one beat accepted (write) or delivered (read).

Behaviour:
- Address split: tag = addr[31:32-TAG_ADDR_LEN], set = next SET_ADDR_LEN bits, word = next LINE_ADDR_LEN bits.
- Per-set state: valid bit, dirty bit, tag, and a line of 2^LINE_ADDR_LEN words.
- req = rd_req | wr_req. If both are high, the access is treated as a store.
- hit = valid[set] & (tag_array[set] == tag).
- `miss` is combinational: (state != IDLE) | (req & !hit & state == IDLE).
  - It is asserted in the same cycle as the missing request.
  - It stays high until the cycle the request hits.
- Read hit: rd_data <= line word at the next clk edge (1-cycle latency).
- rd_data holds its value when there is no read hit.
- Write hit: at the clk edge, write each byte lane whose byte_en bit is set and set dirty[set] = 1. rd_data is unchanged.
- FSM states are IDLE, WRITEBACK and FILL:
  - IDLE -> WRITEBACK when req & !hit & valid & dirty. Latch the victim tag; word_cnt = 0.
  - IDLE -> FILL when req & !hit & !(valid & dirty). word_cnt = 0.
  - On the IDLE -> WRITEBACK/FILL transition, miss_count increments (wraps at 2^32). A stalled request's retry is not counted again.
  - WRITEBACK: mem_req = 1, mem_we = 1, mem_addr uses the victim tag, mem_wdata = line[word_cnt].
    - Each mem_ack increments word_cnt.
    - On the ack of the last word: -> FILL, word_cnt = 0, dirty = 0.
  - FILL: mem_req = 1, mem_we = 0, mem_addr uses the requested tag.
    - Each mem_ack writes mem_rdata into line[word_cnt] and increments word_cnt.
    - On the last ack: tag_array[set] = tag, valid = 1, dirty = 0, -> IDLE.
  - After FILL, the pipeline still holds the request. In the first IDLE cycle it hits and completes normally, so the store merge happens then.
- mem_ack while mem_req = 0 is ignored.
- addr, req and the byte enables must stay stable while `miss` is high; the core's stall guarantees this.
- Reset values, applied asynchronously and immediately:
  - state = IDLE, word_cnt = 0, all valid and dirty = 0, miss_count = 0, rd_data = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Data and tag arrays are not reset.
- Reset mid-burst aborts the burst. Main memory discards the partial burst when mem_req drops.
- Outputs are only defined as in the reset list. All memory-side outputs are 0 in IDLE.

Decomposition:
- Shared package dcache_pkg holds:
  - the FSM state enum (IDLE, WRITEBACK, FILL);
  - the address-field width constants and the field extraction functions;
  - the line-word type.
- One sub-module: dcache_line_ram. It holds the data array with a byte-enabled write port and a combinational read of the selected line word. Tags, valid and dirty stay in dcache_ctrl.

Test Plan:
- Cold read 0x00000010 (memory word i = 0x1000 + i) → `miss` high in the request cycle. Then 8 fill beats at mem_addr 0x00, 0x04, …, 0x1C with mem_we = 0. Next cycle `miss` = 0, and one edge later rd_data = 0x00001004. miss_count = 1.
- After the cold read, store byte_en = 4'b0001, wr_data = 0x000000AB to 0x10, then read 0x10 → no miss, rd_data = 0x000010AB, miss_count unchanged.
- Read 0x00000080 (set 0, different tag) with set 0 dirty → 8 write-back beats at 0x00–0x1C with mem_we = 1 (beat 4 mem_wdata = 0x000010AB). Then 8 fill beats at 0x80–0x9C. rd_data = 0x00001020 (memory word index 0x20). miss_count = 2.
- Miss on a clean line (re-read 0x10 after the previous test) → no write-back beats, fill only. mem_ack held low for 5 cycles mid-burst → word_cnt and mem_addr stall, `miss` stays high.
- Assert rst during fill beat 3 → mem_req = 0, `miss` = 0 and miss_count = 0 immediately. Next read 0x10 misses again. A stray mem_ack after reset has no effect.
- rd_req and wr_req both high to a hitting address → treated as a store: bytes written, dirty set, rd_data unchanged.
